// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter slice.
//   state_t  : arbiter FSM states (IDLE / BUSY)
//   id_width : width of a requester index, never below 1 bit
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Bundle between NUM_REQ producers, the write arbiter and the FIFO write port.
//   req_valid/req_data/req_last : producer beats (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready                   : per-requester accept, one-hot or zero
//   fifo_full                   : FIFO full flag
//   fifo_w_en/fifo_data_in      : FIFO write port
// modport slave  : the arbiter
// modport master : producers + FIFO (environment side)
interface fifo_write_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_w_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_w_en, fifo_data_in
    );

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_w_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req    : request vector
//   rr_ptr : highest-priority index for this pick
//   found  : any request set
//   idx    : first set index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);
    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    int unsigned          pos;

    // Rotate so rr_ptr lands at bit 0, then take the lowest set bit and
    // map it back to an absolute index.
    always_comb begin
        doubled = {req, req} >> rr_ptr;
        rotated = doubled[NUM_REQ-1:0];
        found   = 1'b0;
        idx     = '0;
        pos     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                pos   = 32'(rr_ptr) + i;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                idx = ID_W'(pos);
            end
        end
    end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant lasts until the owner's last beat or MAX_BURST beats; every release
// passes through one IDLE cycle.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : producer + FIFO bundle (slave side)
//   grant_active : high while a grant is held (BUSY)
//   grant_id     : current or most recent owner
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned ID_W      = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_write_arbiter_if.slave  bus,
    output logic                 grant_active,
    output logic [ID_W-1:0]      grant_id
);
    localparam int unsigned   BCW       = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

    state_t          state, state_next;
    logic [ID_W-1:0] owner, owner_next;
    logic [ID_W-1:0] rr_ptr, rr_next;
    logic [BCW-1:0]  beat_cnt, cnt_next;
    logic            found;
    logic [ID_W-1:0] pick;
    logic            wen;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (pick)
    );

    always_comb begin
        state_next       = state;
        owner_next       = owner;
        rr_next          = rr_ptr;
        cnt_next         = beat_cnt;
        wen              = 1'b0;
        bus.req_ready    = '0;
        bus.fifo_w_en    = 1'b0;
        bus.fifo_data_in = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = BUSY;
                    owner_next = pick;
                    rr_next    = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                wen                 = bus.req_valid[owner] & ~bus.fifo_full;
                bus.req_ready[owner] = ~bus.fifo_full;
                bus.fifo_w_en       = wen;
                bus.fifo_data_in    = bus.req_data[owner*DATA_WIDTH +: DATA_WIDTH];
                if (wen) begin
                    cnt_next = beat_cnt + BCW'(1);
                    // last and burst limit on the same beat give one release
                    if (bus.req_last[owner] || (beat_cnt == LAST_BEAT)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            rr_ptr   <= rr_next;
            beat_cnt <= cnt_next;
        end
    end

    assign grant_active = (state == BUSY);
    assign grant_id     = owner;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// MAX_BURST=4, modelled FIFO depth 8). Per-cycle vector table for the single
// packet / reset / owner-stall cases, scoreboard for round-robin, burst limit,
// backpressure and mid-packet reset.
module tb_fifo_write_arbiter;
    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       grant_active;
    logic [1:0] grant_id;

    fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .grant_active (grant_active),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic [3:0]  e_rdy;
        logic        e_wen;
        logic [7:0]  e_din;
        logic        e_ga;
        logic [1:0]  e_gid;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                       input logic [3:0] e_rdy, input logic e_wen, input logic [7:0] e_din,
                       input logic e_ga, input logic [1:0] e_gid);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.l = l;
        t.e_rdy = e_rdy; t.e_wen = e_wen; t.e_din = e_din; t.e_ga = e_ga; t.e_gid = e_gid;
        vecs.push_back(t);
    endtask

    // ---------------- producer / FIFO model + scoreboard ----------------
    typedef struct {
        logic [1:0] id;
        logic [7:0] d;
    } exp_t;
    exp_t exp_q[$];

    logic [8:0]  pbuf [NR][32];
    int unsigned ph [NR];
    int unsigned pt [NR];
    int          fifo_cnt;
    int          wrcount = 0;
    logic        last_wen;
    logic [3:0]  last_rdy;

    task automatic load(input int r, input logic [7:0] d, input logic l);
        pbuf[r][pt[r]] = {l, d};
        pt[r]++;
    endtask

    task automatic expect_beat(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]          = (ph[i] < pt[i]);
            bus.req_data[i*DW +: DW]  = (ph[i] < pt[i]) ? pbuf[i][ph[i]][7:0] : 8'h00;
            bus.req_last[i]           = (ph[i] < pt[i]) ? pbuf[i][ph[i]][8] : 1'b0;
        end
        bus.fifo_full = (fifo_cnt >= DEPTH);
    endtask

    task automatic clear_prod();
        for (int i = 0; i < NR; i++) begin
            ph[i] = 0;
            pt[i] = 0;
        end
        fifo_cnt = 0;
        drive_inputs();
    endtask

    task automatic step(input logic rd);
        logic [3:0] xfer;
        logic       wen;
        exp_t       e;
        @(negedge clk);
        xfer = bus.req_ready & bus.req_valid;
        wen  = bus.fifo_w_en;
        check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
        check("wen_vs_handshake", 32'(wen), 32'(|xfer));
        if (wen) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_data", 32'(bus.fifo_data_in), 32'(e.d));
                check("wr_owner", 32'(grant_id), 32'(e.id));
            end
            wrcount++;
        end
        last_wen = wen;
        last_rdy = bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (xfer[i]) ph[i]++;
        end
        if (wen) fifo_cnt++;
        if (rd && fifo_cnt > 0) fifo_cnt--;
        drive_inputs();
    endtask

    task automatic drain(input string name, input logic rd);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) step(rd);
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) step(rd);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // single packet with a reset mid-run, then owner stall
        //   r     valid    data           last     rdy      wen  din    ga   gid
        add(1'b0, 4'b0001, 32'h0000_0055, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        add(1'b0, 4'b0001, 32'h0000_0055, 4'b0000, 4'b0001, 1'b1, 8'h55, 1'b1, 2'd0);
        add(1'b1, 4'b0001, 32'h0000_0055, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        add(1'b0, 4'b0100, 32'h00A0_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
        add(1'b0, 4'b0100, 32'h00A0_0000, 4'b0000, 4'b0100, 1'b1, 8'hA0, 1'b1, 2'd2);
        add(1'b0, 4'b0100, 32'h00A1_0000, 4'b0000, 4'b0100, 1'b1, 8'hA1, 1'b1, 2'd2);
        add(1'b0, 4'b0100, 32'h00A2_0000, 4'b0100, 4'b0100, 1'b1, 8'hA2, 1'b1, 2'd2);
        add(1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2);
        add(1'b0, 4'b0100, 32'h00B0_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2);
        add(1'b0, 4'b0101, 32'h00B0_00C0, 4'b0000, 4'b0100, 1'b1, 8'hB0, 1'b1, 2'd2);
        add(1'b0, 4'b0001, 32'h00B1_00C0, 4'b0000, 4'b0100, 1'b0, 8'hB1, 1'b1, 2'd2);
        add(1'b0, 4'b0001, 32'h00B1_00C0, 4'b0000, 4'b0100, 1'b0, 8'hB1, 1'b1, 2'd2);
        add(1'b0, 4'b0001, 32'h00B1_00C0, 4'b0000, 4'b0100, 1'b0, 8'hB1, 1'b1, 2'd2);
        add(1'b0, 4'b0101, 32'h00B1_00C0, 4'b0000, 4'b0100, 1'b1, 8'hB1, 1'b1, 2'd2);
        add(1'b0, 4'b0101, 32'h00B2_00C0, 4'b0101, 4'b0100, 1'b1, 8'hB2, 1'b1, 2'd2);
        add(1'b0, 4'b0001, 32'h0000_00C0, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2);
        add(1'b0, 4'b0001, 32'h0000_00C0, 4'b0001, 4'b0001, 1'b1, 8'hC0, 1'b1, 2'd0);
        add(1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].r;
            bus.req_valid = vecs[i].v;
            bus.req_data  = vecs[i].d;
            bus.req_last  = vecs[i].l;
            bus.fifo_full = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d_wen", i), 32'(bus.fifo_w_en), 32'(vecs[i].e_wen));
            check($sformatf("v%0d_din", i), 32'(bus.fifo_data_in), 32'(vecs[i].e_din));
            check($sformatf("v%0d_active", i), 32'(grant_active), 32'(vecs[i].e_ga));
            check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vecs[i].e_gid));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        // round robin: 4 requesters, two single-beat packets each
        clear_prod();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) begin
                load(i, 8'(((2 + k) << 4) | i), 1'b1);
                expect_beat(2'(i), 8'(((2 + k) << 4) | i));
            end
        end
        drive_inputs();
        base = wrcount;
        repeat (16) step(1'b0);
        check("t2_writes_in_16", 32'(wrcount - base), 32'd8);
        drain("t2_drain", 1'b0);

        // burst limit: requester 1 streams 10 beats without last
        clear_prod();
        for (int k = 0; k < 10; k++) load(1, 8'(8'h10 + k), 1'b0);
        load(3, 8'h30, 1'b1);
        load(3, 8'h31, 1'b1);
        for (int k = 0; k < 4; k++) expect_beat(2'd1, 8'(8'h10 + k));
        expect_beat(2'd3, 8'h30);
        for (int k = 4; k < 8; k++) expect_beat(2'd1, 8'(8'h10 + k));
        expect_beat(2'd3, 8'h31);
        expect_beat(2'd1, 8'h18);
        expect_beat(2'd1, 8'h19);
        drive_inputs();
        drain("t3_drain", 1'b1);
        check("t3_hold_active", 32'(grant_active), 32'd1);
        check("t3_hold_id", 32'(grant_id), 32'd1);

        // backpressure: FIFO fills while requester 0 is mid-packet
        clear_prod();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            load(0, 8'(8'h40 + k), (k == 9));
            expect_beat(2'd0, 8'(8'h40 + k));
        end
        drive_inputs();
        base = wrcount;
        for (int k = 0; k < 50 && wrcount - base < 8; k++) step(1'b0);
        check("t4_fill", 32'(wrcount - base), 32'd8);
        for (int k = 0; k < 4; k++) begin
            step(1'b0);
            check("t4_wen_full", 32'(last_wen), 32'd0);
            check("t4_ready_full", 32'(last_rdy), 32'd0);
        end
        check("t4_grant_held", 32'(grant_active), 32'd1);
        base = wrcount;
        step(1'b1);
        repeat (4) step(1'b0);
        check("t4_one_more", 32'(wrcount - base), 32'd1);
        fifo_cnt = 0;
        drive_inputs();
        drain("t4_drain", 1'b0);

        // mid-packet reset on requester 3
        clear_prod();
        for (int k = 0; k < 4; k++) load(3, 8'(8'h60 + k), (k == 3));
        expect_beat(2'd3, 8'h60);
        expect_beat(2'd3, 8'h61);
        drive_inputs();
        base = wrcount;
        for (int k = 0; k < 50 && wrcount - base < 2; k++) step(1'b0);
        check("t5_two_beats", 32'(wrcount - base), 32'd2);
        rst = 1'b1;
        #1;
        check("t5_rst_ready", 32'(bus.req_ready), 32'd0);
        check("t5_rst_wen", 32'(bus.fifo_w_en), 32'd0);
        check("t5_rst_din", 32'(bus.fifo_data_in), 32'd0);
        check("t5_rst_active", 32'(grant_active), 32'd0);
        check("t5_rst_gid", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        load(0, 8'h50, 1'b1);
        expect_beat(2'd0, 8'h50);
        expect_beat(2'd3, 8'h62);
        expect_beat(2'd3, 8'h63);
        drive_inputs();
        drain("t5_drain", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
